apb_pwm_multi: RTL
==================

Name: apb_pwm_multi

Overview:
Multi-channel APB PWM peripheral. It is the parametrised successor of the single-channel apb_pwm that sits behind the apb_mux on the AHB-to-APB bridge. It provides NUM_CH channels driven by one shared period counter, with edge- or center-aligned modes, shadowed period/duty registers that update glitch-free at the period boundary, per-channel polarity, and a period interrupt.

Parameters:
NUM_CH, 4, number of PWM channels (1..8)
CNT_WIDTH, 16, width of the counter, period and duty registers (2..32)
ADDR_WIDTH, 12, width of PADDR; only bits [7:2] are decoded

Ports:
PCLK  input  1  APB clock
PRESETn  input  1  synchronous active-low reset
PSEL  input  1  APB select
PENABLE  input  1  APB access phase
PWRITE  input  1  APB write
PADDR  input  ADDR_WIDTH  byte address
PWDATA  input  32  write data
PRDATA  output  32  read data
PREADY  output  1  always 1
PSLVERR  output  1  error on unmapped access
PWM_OUT  output  NUM_CH  PWM outputs
IRQ  output  1  period-boundary interrupt, level

Behaviour:
- Clocking and reset: single clock PCLK; reset synchronous active-low on PRESETn. On reset, all registers, shadows, the counter and IRQ are 0, direction is up, and PWM_OUT is 0.
- APB: PREADY=1, so there are no wait states. A write commits on PSEL&PENABLE&PWRITE. PRDATA is combinational from PADDR whenever PSEL=1, and 0 otherwise; unused bits read 0. PSLVERR=PSEL&PENABLE&unmapped; an unmapped write changes nothing.
- Register map:
  - 0x00 CTRL: bit0 EN; bit1 MODE (0=edge, 1=center); bit2 IRQEN; bits[8+:NUM_CH] POL.
  - 0x04 PERIOD shadow.
  - 0x08 STATUS: bit0 UPD (write 1 = request shadow load; reads 1 while pending); bit1 PIF (sticky period flag, write 1 to clear).
  - 0x10+4*n DUTY[n] shadow, for n<NUM_CH.
  - Shadows are write/readback only; active copies are not readable.
- Counter, EN=0: cnt held at 0, direction up, PWM_OUT held at POL.
- Counter, edge mode: cnt goes 0..P_act, then wraps to 0. Period is P_act+1 cycles. Boundary = cycle where cnt==P_act.
- Counter, center mode: cnt goes 0..P_act then down P_act-1..1, then back to 0. Period is 2*P_act cycles. Boundary = cycle where the next cnt is 0, i.e. dir=down and cnt==1.
- P_act=0: cnt stays 0 and every cycle is a boundary, in both modes.
- Output: PWM_OUT[n] <= (cnt < D_act[n]) ^ POL[n], registered, so it is 1 cycle behind cnt.
  - D_act=0 gives a constant inactive level.
  - D_act > P_act gives a constant active level.
  - The compare is unsigned, full CNT_WIDTH.
- Shadow load:
  - At a boundary with UPD=1, copy PERIOD to P_act and all DUTY to D_act, then clear UPD.
  - A write to CTRL that takes EN 0->1 loads the shadows immediately and clears UPD.
  - Writing 1 to UPD while EN=0 leaves it pending until enable.
- Simultaneous events:
  - A boundary coinciding with a UPD write=1 loads the shadows and clears UPD; the new request is consumed.
  - A shadow write in a boundary cycle is not loaded until the next UPD.
  - A mode change mid-period takes effect immediately; the counter continues from its current value with direction up.
- Interrupt:
  - PIF is set at every boundary while EN=1.
  - A write-1-clear in the same cycle as a set leaves PIF=1 (set wins).
  - IRQ = PIF & IRQEN, combinational from registers.
- Reset mid-operation returns everything to reset values in the next cycle, and PWM_OUT goes to 0 regardless of POL.

Test Plan:
1. Edge basic: PERIOD=9, DUTY0=3, EN=1 -> PWM_OUT[0] is high 3 cycles then low 7 cycles, repeating with period 10; PIF sets once per 10 cycles.
2. Shadow: while running P=9/D=3, write DUTY0=7 with no UPD -> waveform unchanged; then write UPD=1 mid-period -> STATUS.UPD reads 1 until the boundary, and from the next period the output is high 7 of 10 cycles.
3. Center: MODE=1, PERIOD=4, DUTY0=2, POL0=1 -> period 8 cycles; the cnt sequence 0,1,2,3,4,3,2,1 drives output low for cnt 0,1,1 (3 cycles) and high for 5 cycles.
4. Extremes: DUTY1=0 gives a constant 0; DUTY2=10 with P=9 gives a constant 1; PERIOD=0 with DUTY=1 gives a constant 1 and PIF sets every cycle.
5. APB/IRQ: IRQEN=1 -> IRQ rises after the first boundary. A W1C to PIF coinciding with a boundary leaves IRQ=1. A read of 0x3C with NUM_CH=4 gives PSLVERR=1 and PRDATA=0, and no state changes.
6. Reset: assert PRESETn=0 mid-period with POL=0xF -> after the next PCLK edge, PWM_OUT=0, IRQ=0 and all registers read 0.

Source files
------------

// File: rtl/apb_pwm_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : apb_pwm_multi                                              |
// | Description : Multi-channel APB PWM. Shared period counter (edge or      |
// |               center aligned), shadowed period/duty registers loaded at  |
// |               the period boundary, per-channel polarity, period IRQ.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module apb_pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [NUM_CH-1:0]     PWM_OUT,
  output logic                  IRQ
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // Programmer-visible registers
  logic                 en;
  logic                 mode;
  logic                 irqen;
  logic [NUM_CH-1:0]    pol;
  logic [CNT_WIDTH-1:0] period_sh;
  logic [CNT_WIDTH-1:0] duty_sh [NUM_CH];
  logic                 upd;
  logic                 pif;

  // Active copies and counter state
  logic [CNT_WIDTH-1:0] p_act;
  logic [CNT_WIDTH-1:0] d_act [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt;
  logic                 dir_down;
  logic [NUM_CH-1:0]    pwm_q;

  // Decode and event strobes
  logic [5:0]           word_sel;
  logic                 hit_ctrl;
  logic                 hit_period;
  logic                 hit_status;
  logic [NUM_CH-1:0]    hit_duty;
  logic                 mapped;
  logic                 apb_wr;
  logic                 wr_ctrl;
  logic                 wr_period;
  logic                 wr_status;
  logic                 upd_req;
  logic                 pif_clr;
  logic                 enable_rise;
  logic                 mode_change;
  logic                 boundary;
  logic                 load;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 dir_next;

  // Only PADDR[7:2] and the low PWDATA bits carry meaning
  logic unused_apb_bits;
  assign unused_apb_bits = ^{PADDR, PWDATA};

  assign word_sel   = PADDR[7:2];
  assign hit_ctrl   = (word_sel == 6'd0);
  assign hit_period = (word_sel == 6'd1);
  assign hit_status = (word_sel == 6'd2);

  // One-hot duty register select; words 4..4+NUM_CH-1
  always_comb begin
    hit_duty = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      hit_duty[n] = (word_sel == 6'(4 + n));
    end
  end

  assign mapped      = hit_ctrl | hit_period | hit_status | (|hit_duty);
  assign apb_wr      = PSEL & PENABLE & PWRITE & mapped;
  assign wr_ctrl     = apb_wr & hit_ctrl;
  assign wr_period   = apb_wr & hit_period;
  assign wr_status   = apb_wr & hit_status;
  assign upd_req     = wr_status & PWDATA[0];
  assign pif_clr     = wr_status & PWDATA[1];
  assign enable_rise = wr_ctrl & PWDATA[0] & ~en;
  assign mode_change = wr_ctrl & (PWDATA[1] != mode);

  // A request arriving in the boundary cycle is consumed by that boundary
  assign load = enable_rise | (boundary & (upd | upd_req));

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped;
  assign PWM_OUT = pwm_q;
  assign IRQ     = pif & irqen;

  // Readback mux: shadows and control only, zero for unmapped or idle bus
  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      if (hit_ctrl) begin
        PRDATA[0]           = en;
        PRDATA[1]           = mode;
        PRDATA[2]           = irqen;
        PRDATA[8 +: NUM_CH] = pol;
      end else if (hit_period) begin
        PRDATA = 32'(period_sh);
      end else if (hit_status) begin
        PRDATA[0] = upd;
        PRDATA[1] = pif;
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (hit_duty[n]) PRDATA = 32'(duty_sh[n]);
        end
      end
    end
  end

  // Next counter value, direction and period-boundary detection
  always_comb begin
    boundary = 1'b0;
    cnt_next = cnt;
    dir_next = dir_down;
    if (!en) begin
      cnt_next = CNT_ZERO;
      dir_next = 1'b0;
    end else if (p_act == CNT_ZERO) begin
      boundary = 1'b1;
      cnt_next = CNT_ZERO;
      dir_next = 1'b0;
    end else if (!mode) begin
      dir_next = 1'b0;
      if (cnt == p_act) begin
        boundary = 1'b1;
        cnt_next = CNT_ZERO;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (!dir_down) begin
      if (cnt == p_act) begin
        // With P_act=1 the top is also the last cycle before returning to 0
        if (p_act == CNT_ONE) begin
          boundary = 1'b1;
          cnt_next = CNT_ZERO;
        end else begin
          cnt_next = cnt - CNT_ONE;
          dir_next = 1'b1;
        end
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else begin
      if (cnt == CNT_ONE) begin
        boundary = 1'b1;
        cnt_next = CNT_ZERO;
        dir_next = 1'b0;
      end else begin
        cnt_next = cnt - CNT_ONE;
      end
    end
  end

  // APB-writable control and shadow registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      en        <= 1'b0;
      mode      <= 1'b0;
      irqen     <= 1'b0;
      pol       <= '0;
      period_sh <= '0;
      for (int n = 0; n < NUM_CH; n++) duty_sh[n] <= '0;
    end else begin
      if (wr_ctrl) begin
        en    <= PWDATA[0];
        mode  <= PWDATA[1];
        irqen <= PWDATA[2];
        pol   <= PWDATA[8 +: NUM_CH];
      end
      if (wr_period) period_sh <= PWDATA[CNT_WIDTH-1:0];
      for (int n = 0; n < NUM_CH; n++) begin
        if (apb_wr && hit_duty[n]) duty_sh[n] <= PWDATA[CNT_WIDTH-1:0];
      end
    end
  end

  // Update-request flag and sticky period flag (set beats clear)
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      upd <= 1'b0;
      pif <= 1'b0;
    end else begin
      if (load)         upd <= 1'b0;
      else if (upd_req) upd <= 1'b1;
      pif <= boundary | (pif & ~pif_clr);
    end
  end

  // Counter, direction and active period/duty copies
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt      <= '0;
      dir_down <= 1'b0;
      p_act    <= '0;
      for (int n = 0; n < NUM_CH; n++) d_act[n] <= '0;
    end else begin
      cnt      <= cnt_next;
      dir_down <= mode_change ? 1'b0 : dir_next;
      if (load) begin
        p_act <= period_sh;
        for (int n = 0; n < NUM_CH; n++) d_act[n] <= duty_sh[n];
      end
    end
  end

  // Registered compare: outputs trail the counter by one cycle
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pwm_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        pwm_q[n] <= en ? ((cnt < d_act[n]) ^ pol[n]) : pol[n];
      end
    end
  end

endmodule
`default_nettype wire
